// File: rtl/simmem_pkg.sv
// -----------------------------------------------------------------------------
// simmem_pkg
// Shared types and default parameters for the simulated-memory release
// scheduler. The slot record is sized by the default parameters below, so a
// scheduler instance must use those same values for NumSlots, IDWidth and
// CounterWidth.
// -----------------------------------------------------------------------------
package simmem_pkg;

   localparam int unsigned NumSlotsDef     = 8;
   localparam int unsigned IDWidthDef      = 4;
   localparam int unsigned CounterWidthDef = 8;

   // One tracked transaction. predMask has one bit per slot. A set bit names
   // an older slot with the same ID that must leave before this slot may be
   // released.
   typedef struct packed {
      logic                       valid;
      logic [IDWidthDef-1:0]      id;
      logic [CounterWidthDef-1:0] counter;
      logic [NumSlotsDef-1:0]     predMask;
   } slot_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// simmem_rr_arbiter
// Combinational round-robin search. It grants the first requesting index,
// starting one past ptr_i and wrapping around. ptr_i itself is tried last.
//
// Ports:
//   req_i   - one request bit per slot
//   ptr_i   - index of the most recently granted slot
//   grant_o - one-hot grant (all zero when nothing requests)
//   valid_o - high when grant_o has a bit set
// -----------------------------------------------------------------------------
module simmem_rr_arbiter #(
   parameter  int unsigned NumReq   = 8,
   localparam int unsigned PtrWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req_i,
   input  logic [PtrWidth-1:0] ptr_i,
   output logic [NumReq-1:0]   grant_o,
   output logic                valid_o
);

   logic [PtrWidth-1:0] idx;

   // Walk the offsets 1..NumReq from the pointer. The first requester found
   // wins, so offset NumReq (the pointer itself) has the lowest priority.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int off = 1; off <= int'(NumReq); off++) begin
         idx = PtrWidth'((int'(ptr_i) + off) % int'(NumReq));
         if (!valid_o && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simmem_release_scheduler.sv
// -----------------------------------------------------------------------------
// simmem_release_scheduler
// Tracks up to NumSlots outstanding AXI transactions. Each transaction counts
// down its own release delay. Transactions are then released one at a time
// through a registered valid/ready output. Releases with the same ID leave in
// acceptance order.
//
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   req_valid_i/ready_o    - transaction offer / slot available
//   req_id_i, req_delay_i  - ID and release delay (cycles) of the offer
//   rel_valid_o/ready_i    - release pending / consumed by the message bank
//   rel_id_o               - ID being released
//   occupancy_o            - number of occupied slots (registered)
// -----------------------------------------------------------------------------
module simmem_release_scheduler
   import simmem_pkg::*;
#(
   parameter  int unsigned NumSlots     = NumSlotsDef,
   parameter  int unsigned IDWidth      = IDWidthDef,
   parameter  int unsigned CounterWidth = CounterWidthDef,
   localparam int unsigned OccWidth     = $clog2(NumSlots + 1),
   localparam int unsigned PtrWidth     = $clog2(NumSlots)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [IDWidth-1:0]      req_id_i,
   input  logic [CounterWidth-1:0] req_delay_i,
   output logic                    rel_valid_o,
   input  logic                    rel_ready_i,
   output logic [IDWidth-1:0]      rel_id_o,
   output logic [OccWidth-1:0]     occupancy_o
);

   slot_t               slots_q [NumSlots];
   slot_t               slots_d [NumSlots];
   logic [PtrWidth-1:0] ptr_q, ptr_d;
   logic [PtrWidth-1:0] heldIdx_q, heldIdx_d;
   logic                relValid_q, relValid_d;
   logic [IDWidth-1:0]  relId_q, relId_d;
   logic [OccWidth-1:0] occ_q, occ_d;

   logic [NumSlots-1:0] freeVec, sameId, eligible, freeMask, grant;
   logic [PtrWidth-1:0] allocIdx, grantIdx, searchPtr;
   logic                anyFree, accept, handshake, loadOut, grantValid;

   // Per-slot status derived only from registered state. The slot held in the
   // output register is not eligible, so it cannot be granted twice.
   always_comb begin
      freeVec  = '0;
      sameId   = '0;
      eligible = '0;
      for (int i = 0; i < int'(NumSlots); i++) begin
         freeVec[i]  = !slots_q[i].valid;
         sameId[i]   = slots_q[i].valid && (slots_q[i].id == req_id_i);
         eligible[i] = slots_q[i].valid && (slots_q[i].counter == '0) &&
                       (slots_q[i].predMask == '0) &&
                       !(relValid_q && (heldIdx_q == PtrWidth'(i)));
      end
   end

   // The lowest-index free slot receives the next accepted transaction.
   always_comb begin
      allocIdx = '0;
      for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
         if (freeVec[i]) begin
            allocIdx = PtrWidth'(i);
         end
      end
   end

   // Readiness depends only on registered occupancy. A slot freed this cycle
   // therefore becomes usable one cycle later.
   assign anyFree     = |freeVec;
   assign req_ready_o = anyFree && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign handshake   = relValid_q && rel_ready_i;
   assign loadOut     = !relValid_q || handshake;
   assign freeMask    = handshake ? (NumSlots'(1) << heldIdx_q) : '0;

   // The slot being handed over this cycle counts as the most recent grant.
   // The replacement search therefore starts just past it.
   assign searchPtr = handshake ? heldIdx_q : ptr_q;

   simmem_rr_arbiter #(
      .NumReq (NumSlots)
   ) uArbiter (
      .req_i   (eligible),
      .ptr_i   (searchPtr),
      .grant_o (grant),
      .valid_o (grantValid)
   );

   always_comb begin
      grantIdx = '0;
      for (int i = 0; i < int'(NumSlots); i++) begin
         if (grant[i]) begin
            grantIdx = PtrWidth'(i);
         end
      end
   end

   // Slot next state. Each counter decrements and saturates at zero. The
   // slot being freed drops out of every predecessor mask. A new entry
   // depends on every same-ID slot still present after this cycle.
   always_comb begin
      for (int i = 0; i < int'(NumSlots); i++) begin
         slots_d[i] = slots_q[i];
         if (slots_q[i].valid && (slots_q[i].counter != '0)) begin
            slots_d[i].counter = slots_q[i].counter - 1'b1;
         end
         slots_d[i].predMask = slots_q[i].predMask & ~freeMask;
         if (freeMask[i]) begin
            slots_d[i] = '0;
         end
      end
      if (accept) begin
         slots_d[allocIdx].valid    = 1'b1;
         slots_d[allocIdx].id       = req_id_i;
         slots_d[allocIdx].counter  = req_delay_i;
         slots_d[allocIdx].predMask = sameId & ~freeMask;
      end
   end

   // Output register, pointer and occupancy next state. While the bank stalls,
   // the held release stays untouched.
   always_comb begin
      relValid_d = relValid_q;
      relId_d    = relId_q;
      heldIdx_d  = heldIdx_q;
      if (loadOut) begin
         relValid_d = grantValid;
         if (grantValid) begin
            relId_d   = slots_q[grantIdx].id;
            heldIdx_d = grantIdx;
         end
      end
      ptr_d = handshake ? heldIdx_q : ptr_q;
      occ_d = occ_q;
      if (accept && !handshake) begin
         occ_d = occ_q + OccWidth'(1);
      end else if (!accept && handshake) begin
         occ_d = occ_q - OccWidth'(1);
      end
   end

   // State registers. Reset discards all pending work.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NumSlots); i++) begin
            slots_q[i] <= '0;
         end
         ptr_q      <= PtrWidth'(NumSlots - 1);
         heldIdx_q  <= '0;
         relValid_q <= 1'b0;
         relId_q    <= '0;
         occ_q      <= '0;
      end else begin
         slots_q    <= slots_d;
         ptr_q      <= ptr_d;
         heldIdx_q  <= heldIdx_d;
         relValid_q <= relValid_d;
         relId_q    <= relId_d;
         occ_q      <= occ_d;
      end
   end

   assign rel_valid_o = relValid_q;
   assign rel_id_o    = relId_q;
   assign occupancy_o = occ_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// -----------------------------------------------------------------------------
// tb_simmem_release_scheduler
// Scoreboard bench for simmem_release_scheduler. Every accepted transaction is
// recorded with its ID, acceptance cycle and delay. The monitor checks each
// release against that record:
//   - the ID must have an outstanding transaction;
//   - the oldest transaction with that ID is retired first;
//   - it must be at least delay+2 cycles old.
// The monitor also tracks occupancy and readiness.
// -----------------------------------------------------------------------------
module tb_simmem_release_scheduler;

   localparam int NumSlots = 8;

   typedef struct {
      logic [3:0] id;
      int         t;
      int         d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       reqValid;
   logic       reqReady;
   logic [3:0] reqId;
   logic [7:0] reqDelay;
   logic       relValid;
   logic       relReady;
   logic [3:0] relId;
   logic [3:0] occ;

   int   cyc      = 0;
   int   tests    = 0;
   int   fails    = 0;
   int   modelOcc = 0;
   bit   monEn    = 1'b0;
   bit   prevStall = 1'b0;
   logic [3:0] prevId = '0;
   exp_t expQ[$];

   simmem_release_scheduler dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (reqValid),
      .req_ready_o (reqReady),
      .req_id_i    (reqId),
      .req_delay_i (reqDelay),
      .rel_valid_o (relValid),
      .rel_ready_i (relReady),
      .rel_id_o    (relId),
      .occupancy_o (occ)
   );

   always #5 clk = ~clk;

   // Cycle k is the interval after the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Records one comparison. Reports it when the values differ.
   task automatic checkOutput(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge and returns at the
   // falling edge. An accepted request is recorded in the scoreboard.
   task automatic applyStimulus(input bit v, input logic [3:0] id, input logic [7:0] d,
                                input bit rdy, output bit acc, output int t);
      @(posedge clk);
      #1;
      reqValid = v;
      reqId    = id;
      reqDelay = d;
      relReady = rdy;
      @(negedge clk);
      acc = v && reqReady;
      t   = cyc;
      if (acc) expQ.push_back('{id: id, t: cyc, d: int'(d)});
   endtask

   task automatic idleCycle(input bit rdy);
      bit a;
      int t;
      applyStimulus(1'b0, 4'd0, 8'd0, rdy, a, t);
   endtask

   // Waits a bounded number of cycles for rel_valid_o. Returns -1 on timeout.
   task automatic waitRel(input int limit, input bit rdy, output int at);
      at = -1;
      for (int k = 0; k < limit; k++) begin
         idleCycle(rdy);
         if (relValid) begin
            at = cyc;
            break;
         end
      end
      checkOutput("waitRelTimeout", (at >= 0), 1);
   endtask

   task automatic applyReset(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         rst      = 1'b1;
         reqValid = 1'b0;
         relReady = 1'b0;
         @(negedge clk);
         checkOutput("readyInReset", reqReady, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postResetReady", reqReady, 1);
      checkOutput("postResetOcc", occ, 0);
      checkOutput("postResetRelValid", relValid, 0);
      checkOutput("postResetRelId", relId, 0);
   endtask

   task automatic drain();
      for (int k = 0; k < 400 && (expQ.size() != 0 || occ != 0); k++) idleCycle(1'b1);
      checkOutput("drainQueue", expQ.size(), 0);
      checkOutput("drainOcc", occ, 0);
   endtask

   // Monitor: reference occupancy, ready, hold stability and release legality.
   always @(negedge clk) begin
      if (monEn) begin
         if (rst) begin
            expQ.delete();
            modelOcc  = 0;
            prevStall = 1'b0;
         end else begin
            int  idx;
            bit  hs;
            bit  acc;
            checkOutput("occupancy", occ, modelOcc);
            checkOutput("reqReady", reqReady, (modelOcc < NumSlots));
            if (prevStall) begin
               checkOutput("holdValid", relValid, 1);
               checkOutput("holdId", relId, prevId);
            end
            hs  = relValid && relReady;
            acc = reqValid && reqReady;
            if (relValid) begin
               idx = -1;
               for (int i = 0; i < expQ.size(); i++) begin
                  if (expQ[i].id == relId) begin
                     idx = i;
                     break;
                  end
               end
               checkOutput("releaseKnownId", (idx >= 0), 1);
               if (idx >= 0 && hs) begin
                  checkOutput("releaseNotEarly", (cyc >= expQ[idx].t + expQ[idx].d + 2), 1);
                  expQ.delete(idx);
               end
            end
            modelOcc  = modelOcc + int'(acc) - int'(hs);
            prevStall = relValid && !relReady;
            prevId    = relId;
         end
      end
   end

   // Accepts one request and returns the acceptance cycle.
   task automatic acceptOne(input logic [3:0] id, input logic [7:0] d, input bit rdy, output int t);
      bit a;
      applyStimulus(1'b1, id, d, rdy, a, t);
      checkOutput("acceptOne", a, 1);
   endtask

   task automatic latencyTest(input logic [3:0] id, input logic [7:0] d, input string name);
      int t;
      int at;
      acceptOne(id, d, 1'b1, t);
      waitRel(int'(d) + 10, 1'b1, at);
      checkOutput(name, at - t, int'(d) + 2);
      checkOutput({name, "Id"}, relId, id);
      idleCycle(1'b1);
      checkOutput({name, "SinglePulse"}, relValid, 0);
      checkOutput({name, "OccEmpty"}, occ, 0);
   endtask

   initial begin
      int  t, at, at2;
      bit  a;
      logic [3:0] ids [3];
      rst = 1'b1; reqValid = 1'b0; reqId = '0; reqDelay = '0; relReady = 1'b0;

      applyReset(2);
      monEn = 1'b1;

      // Single release: ID 3 with delay 5, then delay 0 and delay 255.
      latencyTest(4'd3, 8'd5, "latD5");
      latencyTest(4'd9, 8'd0, "latD0");
      latencyTest(4'd1, 8'd255, "latD255");

      // Same ID: the long-delay transaction must release first.
      acceptOne(4'd2, 8'd9, 1'b1, t);
      acceptOne(4'd2, 8'd1, 1'b1, at);
      waitRel(20, 1'b1, at);
      checkOutput("sameIdFirst", at - t, 11);
      waitRel(20, 1'b1, at2);
      checkOutput("sameIdSecondAfter", (at2 > at), 1);
      checkOutput("sameIdSecondId", relId, 2);
      drain();

      // Three IDs due together after reset: slot order 0,1,2 with a stall.
      applyReset(1);
      ids[0] = 4'd5; ids[1] = 4'd6; ids[2] = 4'd7;
      acceptOne(ids[0], 8'd4, 1'b0, t);
      acceptOne(ids[1], 8'd3, 1'b0, at);
      acceptOne(ids[2], 8'd2, 1'b0, at);
      waitRel(10, 1'b0, at);
      checkOutput("rrFirstLatency", at - t, 6);
      for (int k = 0; k < 3; k++) begin
         idleCycle(1'b0);
         checkOutput("rrStallId", relId, ids[0]);
      end
      for (int k = 0; k < 3; k++) begin
         idleCycle(1'b1);
         checkOutput("rrValid", relValid, 1);
         checkOutput("rrOrderId", relId, ids[k]);
      end
      drain();

      // Fill every slot, then free exactly one.
      for (int k = 0; k < NumSlots; k++) acceptOne(4'(k), 8'd20, 1'b0, t);
      idleCycle(1'b0);
      checkOutput("fullNotReady", reqReady, 0);
      waitRel(30, 1'b0, at);
      idleCycle(1'b1);
      checkOutput("freedSameCycleNotReady", reqReady, 0);
      idleCycle(1'b0);
      checkOutput("freedNextCycleReady", reqReady, 1);
      drain();

      // Reset with five transactions pending: nothing may be released later.
      for (int k = 0; k < 5; k++) acceptOne(4'(k + 8), 8'(30 + k), 1'b1, t);
      applyReset(1);
      at = 0;
      for (int k = 0; k < 60; k++) begin
         idleCycle(k[0]);
         if (relValid) at++;
      end
      checkOutput("noReleaseAfterReset", at, 0);
      checkOutput("occAfterReset", occ, 0);

      // Random traffic with frequent ID collisions.
      for (int k = 0; k < 1500; k++) begin
         applyStimulus(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 3)),
                       8'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), a, t);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/simmem_release_scheduler.md
SIMMEM_RELEASE_SCHEDULER -- requirements
Module: simmem_release_scheduler

Interface
REQ-001 SHALL have parameter NumSlots, default 8, the number of outstanding transactions tracked.
REQ-002 SHALL have parameter IDWidth, default 4, the AXI transaction ID width.
REQ-003 SHALL have parameter CounterWidth, default 8, the delay counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: the clock.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: a new transaction is offered.
REQ-008 SHALL have port req_ready_o, output, 1 bit: the scheduler can accept a transaction.
REQ-009 SHALL have port req_id_i, input, IDWidth bits: the transaction ID.
REQ-010 SHALL have port req_delay_i, input, CounterWidth bits: the release delay in cycles.
REQ-011 SHALL have port rel_valid_o, output, 1 bit: a release is pending.
REQ-012 SHALL have port rel_ready_i, input, 1 bit: the message bank consumes the release.
REQ-013 SHALL have port rel_id_o, output, IDWidth bits: the ID being released.
REQ-014 SHALL have port occupancy_o, output, clog2(NumSlots+1) bits: the number of occupied slots.

Function
REQ-015 Each slot SHALL hold: valid, id, counter, and a NumSlots-bit predecessor mask.
REQ-016 Acceptance SHALL occur on req_valid_i && req_ready_o.
REQ-017 req_ready_o SHALL be 1 exactly when at least one slot is free, computed from registered state only.
- A slot freed in the same cycle SHALL NOT raise req_ready_o in that cycle.
REQ-018 On acceptance, the lowest-index free slot SHALL be allocated with:
- counter = req_delay_i;
- predecessor mask = the set of valid slots with the same ID, including those leaving that cycle, cleared per REQ-021.
REQ-019 Every valid slot with a nonzero counter SHALL decrement by 1 per cycle, saturating at 0 with no wrap.
REQ-020 A slot SHALL be eligible when it is valid, its counter is 0, its predecessor mask is all-zero, and it is not held in the output register.
REQ-021 When a slot is freed, its bit SHALL clear in every slot's predecessor mask in the same cycle.
- This guarantees in-order release per ID.
REQ-022 Output register (rel_valid_o, rel_id_o, held slot index):
- SHALL load when empty or when the handshake rel_valid_o && rel_ready_i occurs.
- SHALL take the first eligible slot searching round-robin from one past the last granted index.
- rel_valid_o SHALL fall if no slot is eligible.
REQ-023 While rel_valid_o=1 and rel_ready_i=0, rel_valid_o and rel_id_o SHALL be held stable.
REQ-024 On the handshake, the held slot SHALL be freed and the round-robin pointer SHALL advance to that slot's index.
REQ-025 Latency:
- A transaction accepted at cycle T with delay D SHALL assert rel_valid_o no earlier than T+D+2.
- It SHALL assert exactly at T+D+2 when it has no predecessor and the output register is free.
- D=0 SHALL therefore give T+2.
REQ-026 Simultaneous allocation and release in one cycle SHALL both take effect; occupancy_o SHALL be unchanged.
REQ-027 occupancy_o SHALL equal the number of valid slots, registered.
REQ-028 rel_ready_i asserted with rel_valid_o=0 SHALL be ignored.

Reset
REQ-029 While rst_i=1, on the clock edge:
- all slots SHALL become invalid, with counters and masks set to 0;
- the pointer SHALL be set to NumSlots-1;
- rel_valid_o=0, rel_id_o=0, occupancy_o=0.
REQ-030 req_ready_o SHALL be 0 while rst_i=1 and SHALL be 1 in the first cycle after reset.
REQ-031 Reset mid-operation SHALL discard all pending transactions, with no release emitted afterwards.

Structure
REQ-032 The slot struct type and the default parameters SHALL live in simmem_pkg.
REQ-033 The round-robin search SHALL be a sub-module simmem_rr_arbiter (NumSlots request bits, pointer in, one-hot grant plus valid out).

Verification
REQ-034 Accept ID 3 with delay 5 at cycle 10, rel_ready_i=1 -> rel_valid_o=1 with rel_id_o=3 at cycle 17 only; occupancy_o returns to 0.
REQ-035 Accept ID 2 with delay 9, then ID 2 with delay 1 -> the second is released strictly after the first.
REQ-036 Fill all 8 slots with delay 20 -> req_ready_o=0; one handshake frees a slot; req_ready_o=1 one cycle later.
REQ-037 Three different IDs due together, rel_ready_i=1 -> one release per cycle in round-robin slot order; hold rel_ready_i=0 -> rel_id_o stays stable.
REQ-038 Delay 0 accepted at cycle T -> rel_valid_o at T+2; with delay 255 -> rel_valid_o at T+257, with no wrap.
REQ-039 Assert rst_i with 5 slots pending -> no rel_valid_o afterwards; occupancy_o=0; req_ready_o=1.
